// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_stream                                                           |
// | Read-side unloader: async-FIFO read port -> valid/ready stream through   |
// | a 3-entry skid buffer. Define FIFO_RD_STATS_EN to enable word_cnt.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [1:0] PTR_LAST = 2'd2;
  localparam logic [2:0] SLOTS    = 3'd3;

  logic [DATA_WIDTH-1:0] mem_q [0:2];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pend_q;
  logic [2:0]            inflight;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are issued against buffered plus in-flight words, so a capture
  // always finds a free slot and m_ready never reaches fifo_rd_en.
  assign inflight   = {1'b0, occ_q} + {2'b0, pend_q};
  assign fifo_rd_en = rst_n && !fifo_empty && (inflight < SLOTS);
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = mem_q[head_q];
  assign capture    = pend_q;
  assign pop        = m_valid && m_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (capture) tail_d = ptr_inc(tail_q);
    if (pop)     head_d = ptr_inc(head_q);
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      pend_q <= fifo_rd_en;
      if (capture) mem_q[tail_q] <= fifo_rd_data;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign cnt_d = pop ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign word_cnt = cnt_q;
`else
  assign word_cnt = '0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) inflight <= SLOTS);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_stream                                                        |
// | Directed self-checking bench with a behavioural FIFO read-port model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_cnt;

  int checks = 0;
  int errors = 0;

  // FIFO model: the bench owns wr_ptr, the model owns rd_ptr.
  logic [DW-1:0] mem [0:1023];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .word_cnt     (word_cnt)
  );

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr % 1024] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  // Leaves rst_n low with the FIFO model emptied.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    m_ready = 1'b0;
    wr_ptr  = rd_ptr;
    repeat (2) @(negedge clk);
  endtask

  // Called at a sample point (negedge+1) with m_ready=1 and no further pushes.
  task automatic drain(input logic [DW-1:0] first, input int n, input int budget);
    int k = 0;
    int cyc = 0;
    bit started = 1'b0;
    logic [DW-1:0] e;
    while (k < n && cyc < budget) begin
      if (m_valid) begin
        started = 1'b1;
        e = first + k[DW-1:0];
        checks++;
        if (m_data !== e) begin
          errors++;
          $display("FAIL drain_word[%0d]: got %h expected %h", k, m_data, e);
        end
        k++;
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL drain_bubble[%0d]: m_valid got 0 expected 1", k);
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    if (k < n) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words expected %0d", k, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h11 + i[7:0]);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || word_cnt !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b rd_en=%b cnt=%0d data=%h expected 0 0 0 00",
               m_valid, fifo_rd_en, word_cnt, m_data);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_rd_en: got %b expected 1", fifo_rd_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_latency_c1: m_valid got %b expected 0", m_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_latency_c2: m_valid got %b expected 1", m_valid);
    end
    drain(8'h11, 5, 20);
  endtask

  task automatic test_streaming();
    logic [CW-1:0] exp_cnt;
    do_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(i[7:0]);
    #1;
    drain(8'h01, 16, 40);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end_valid: got %b expected 0", m_valid);
    end
`ifdef FIFO_RD_STATS_EN
    exp_cnt = 4'd0;  // 16 transfers wrap a 4-bit counter
`else
    exp_cnt = 4'd0;
`endif
    checks++;
    if (word_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL stream_word_cnt: got %0d expected %0d", word_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    do_reset();
    for (int i = 1; i <= 8; i++) push(i[7:0]);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (fifo_rd_en && !fifo_empty) reads++;
      if (c >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
          errors++;
          $display("FAIL bp_hold[%0d]: valid=%b data=%h expected 1 01", c, m_valid, m_data);
        end
      end
      if (c < 9) begin
        @(negedge clk);
        #1;
      end
    end
    checks++;
    if (reads != 3) begin
      errors++;
      $display("FAIL bp_reads: got %0d expected 3", reads);
    end
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_rd_en_low: got %b expected 0", fifo_rd_en);
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    drain(8'h01, 8, 30);
  endtask

  task automatic test_random_ready();
    int pushed = 0;
    int got = 0;
    int pops = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [DW-1:0] prev = '0;
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      if (cyc > 0) @(negedge clk);
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push(pushed[7:0]);
        pushed++;
      end
      m_ready = ($urandom_range(0, 1) == 1);
      #1;
      cyc++;
      if (hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev) begin
          errors++;
          $display("FAIL rand_stable: valid=%b data=%h expected 1 %h", m_valid, m_data, prev);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== got[7:0]) begin
          errors++;
          $display("FAIL rand_order[%0d]: got %h expected %h", got, m_data, got[7:0]);
        end
        got++;
      end
      if (fifo_rd_en && !fifo_empty) pops++;
      checks++;
      if (pops - got > 3) begin
        errors++;
        $display("FAIL rand_inflight: got %0d expected <= 3", pops - got);
      end
      hold = m_valid && !m_ready;
      prev = m_data;
    end
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL rand_timeout: got %0d words expected 1000", got);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 1; i <= 8; i++) push(i[7:0]);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_state: rd_en=%b valid=%b expected 0 1", fifo_rd_en, m_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || fifo_rd_en !== 1'b0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b data=%h rd_en=%b cnt=%0d expected 0 00 0 0",
               m_valid, m_data, fifo_rd_en, word_cnt);
    end
    wr_ptr = rd_ptr;
    for (int i = 0; i < 6; i++) push(8'hA0 + i[7:0]);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1;
    drain(8'hA0, 6, 20);
  endtask

  task automatic test_counter_wrap();
    logic [CW-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 17; i++) push(8'h30 + i[7:0]);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1;
    drain(8'h30, 17, 40);
`ifdef FIFO_RD_STATS_EN
    exp_cnt = 4'd1;
`else
    exp_cnt = 4'd0;
`endif
    checks++;
    if (word_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL wrap_word_cnt: got %0d expected %0d", word_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random_ready();
    test_reset_midstream();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side unloader for the async FIFO. It sits in the read clock domain and drives the FIFO read port: it issues `fifo_rd_en`, captures `fifo_rd_data` one cycle later and presents the words as a valid/ready stream. A 3-entry skid buffer lets it sustain one word per cycle without any combinational path from `m_ready` to `fifo_rd_en`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: FIFO word width.
- `CNT_WIDTH`, default 16: width of the statistics counter.

Ports:
- `clk`  in  1  read-domain clock; the FIFO's `rd_clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data; valid in the cycle after an accepted read.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DATA_WIDTH  stream word.
- `word_cnt`  out  CNT_WIDTH  accepted-transfer count; tied to 0 unless `FIFO_RD_STATS_EN` is defined.

## Operation
FIFO read contract:
- An edge with `fifo_rd_en=1` and `fifo_empty=0` pops one word.
- The popped word appears on `fifo_rd_data` during the next cycle.

Internal state, all registered:
- `pend` (1 bit): a read was issued at the last edge; its data is on `fifo_rd_data` this cycle.
- `occ` (0..3): buffered words, held in a 3-entry circular buffer with 2-bit head/tail pointers that wrap 2→0.

Read issue:
- `fifo_rd_en = !fifo_empty && (occ + pend < 3)`.
- It depends only on registers and `fifo_empty`.

Capture and pop:
- If `pend=1`, `fifo_rd_data` is written at the tail. Tail and `occ` increment.
- If `m_valid && m_ready`, the head advances and `occ` decrements.
- Capture and pop on the same edge leave `occ` unchanged.

Stream outputs:
- `m_valid = (occ != 0)`.
- `m_data` = buffer[head], taken from registered storage.

Occupancy states:
- EMPTY (`occ=0`): `m_valid=0`.
- PART (`occ` = 1 or 2): `m_valid=1`.
- FULL (`occ=3`): `m_valid=1`, `fifo_rd_en=0`.
- Transitions: +1 on capture without pop, −1 on pop without capture, hold otherwise.
- `occ + pend` never exceeds 3, so a capture never hits a full buffer. This is an assertion.

Stream rules:
- `m_data` is stable while `m_valid && !m_ready`.
- Words leave in FIFO order with no loss or duplication.
- `m_valid` never drops without a transfer.

Reset (`rst_n` low, at any time):
- `occ=0`, `pend=0`, pointers 0, `word_cnt=0`.
- Outputs: `m_valid=0`, `m_data=0`, `fifo_rd_en=0` (forced low while `rst_n=0`).
- A read in flight at reset is discarded. The FIFO must share the same reset so that pointers stay consistent.

## Timing
- Empty to first word: `fifo_empty` low in cycle c gives `fifo_rd_en=1` in c, data on `fifo_rd_data` in c+1, and `m_valid=1` in c+2. Latency is 2 cycles.
- Throughput: 1 word/cycle when the FIFO is non-empty and `m_ready=1`. Steady state is `occ=1`, `pend=1`.
- Backpressure with `m_ready=0`: at most 3 words are buffered. `fifo_rd_en` falls in the cycle where `occ+pend=3`.
- On `m_ready` returning, the first pop is in the same cycle. The next FIFO read is issued in that cycle's successor, and the buffer covers the 2-cycle refill gap without a bubble.
- `fifo_empty` rising mid-stream stops issue in the same cycle. Buffered and pending words still drain.
- No combinational path from `m_ready` to `fifo_rd_en`. `m_valid` and `m_data` are registered.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `word_cnt` increments on each `m_valid && m_ready` edge.
  - It wraps modulo 2^CNT_WIDTH and resets to 0.
- `FIFO_RD_STATS_EN` undefined:
  - The counter logic is absent and `word_cnt` is constant 0.
  - The port stays, so the interface is unchanged.

## Test plan
- **Reset:** hold `rst_n=0` with the FIFO holding 5 words → `m_valid=0`, `fifo_rd_en=0`, `word_cnt=0`. After release, the first `m_valid` comes 2 cycles after the first `fifo_rd_en`.
- **Streaming:** write 0x01..0x10, then hold `m_ready=1` → `m_data` is 0x01..0x10 on 16 consecutive cycles with no bubble. Then `m_valid=0`, and `word_cnt=16` when stats are enabled.
- **Backpressure:** FIFO holds 8 words, `m_ready=0` for 10 cycles → exactly 3 reads issued, `fifo_rd_en=0` afterwards, `m_data=0x01` stable. After release, the words arrive in order 0x01..0x08.
- **Random ready:** FIFO trickle-filled, `m_ready` random at 50% for 1000 words → order preserved, no drop or duplicate, `occ+pend≤3` always.
- **Reset mid-stream:** reset with `occ=2`, `pend=1` → all outputs are 0 the next cycle. After restart (FIFO also reset), new data 0xA0.. streams correctly.
- **Counter wrap:** build with `FIFO_RD_STATS_EN` and `CNT_WIDTH=4`, transfer 17 words → `word_cnt=1`. Build without the macro → `word_cnt=0` throughout.
